// File: rtl/idct_8_mac_if.sv
// idct_8_mac_if: coefficient fetch port and sample output stream of the 8-point IDCT
interface idct_8_mac_if #(
    parameter int COEF_WIDTH = 12,
    parameter int OUT_WIDTH  = 8
);
    logic [2:0]                   fetch_addr;
    logic signed [COEF_WIDTH-1:0] fetch_data;
    logic                         fetch_clk;
    logic                         out_valid;
    logic                         out_ready;
    logic [2:0]                   out_index;
    logic [OUT_WIDTH-1:0]         out_data;

    modport master (
        output fetch_addr, fetch_clk, out_valid, out_index, out_data,
        input  fetch_data, out_ready
    );

    modport slave (
        input  fetch_addr, fetch_clk, out_valid, out_index, out_data,
        output fetch_data, out_ready
    );
endinterface

// File: rtl/idct_8_mac.sv
// idct_8_mac: sequential 8-point IDCT, one MAC per cycle; IDCT_LEVEL_SHIFT_EN selects unsigned level-shifted output
module idct_8_mac #(
    parameter int COEF_WIDTH = 12,
    parameter int OUT_WIDTH  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    idct_8_mac_if.master bus
);
    typedef enum logic [2:0] {IDLE, MAC, FINISH, OUT, DONE} state_t;

`ifdef IDCT_LEVEL_SHIFT_EN
    localparam logic signed [31:0] OFS = 32'(2 ** (OUT_WIDTH - 1));
    localparam logic signed [31:0] LO  = 32'sd0;
    localparam logic signed [31:0] HI  = 32'(2 ** OUT_WIDTH - 1);
`else
    localparam logic signed [31:0] OFS = 32'sd0;
    localparam logic signed [31:0] LO  = -32'(2 ** (OUT_WIDTH - 1));
    localparam logic signed [31:0] HI  = 32'(2 ** (OUT_WIDTH - 1) - 1);
`endif

    state_t             state;
    logic [2:0]         n;
    logic [2:0]         k;
    logic signed [31:0] acc;
    logic signed [9:0]  b;
    logic signed [31:0] prod;
    logic signed [31:0] y;
    logic signed [31:0] ys;
    logic [OUT_WIDTH-1:0] sat;

    function automatic logic signed [9:0] cos_tab(input logic [4:0] m);
        case (m)
            5'd0:    return 10'sd128;
            5'd1:    return 10'sd126;
            5'd2:    return 10'sd118;
            5'd3:    return 10'sd106;
            5'd4:    return 10'sd91;
            5'd5:    return 10'sd71;
            5'd6:    return 10'sd49;
            5'd7:    return 10'sd25;
            default: return 10'sd0;
        endcase
    endfunction

    // 128*cos(m*pi/16) folded onto the first quadrant; the DC column uses 256/(2*sqrt(2)) = 91
    function automatic logic signed [9:0] basis(input logic [2:0] nn, input logic [2:0] kk);
        logic [4:0]        m;
        logic [4:0]        f;
        logic signed [9:0] t;
        m = {1'b0, nn, 1'b1} * {2'b0, kk};
        f = (m > 5'd16) ? 5'd0 - m : m;
        t = cos_tab(f > 5'd8 ? 5'd16 - f : f);
        return (kk == 3'd0) ? 10'sd91 : (f > 5'd8 ? -t : t);
    endfunction

    // FINISH folds the last returned coefficient into the rounded result combinationally
    assign b    = basis(n, state == FINISH ? 3'd7 : k - 3'd1);
    assign prod = 32'(bus.fetch_data) * 32'(b);
    assign y    = (acc + prod + 32'sd128) >>> 8;
    assign ys   = y + OFS;
    assign sat  = OUT_WIDTH'(ys < LO ? LO : (ys > HI ? HI : ys));

    assign bus.fetch_clk  = clock;
    assign bus.fetch_addr = k;

    // Control FSM: fetch/accumulate per sample, round and saturate, then hand off over the stream
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            n             <= 3'd0;
            k             <= 3'd0;
            acc           <= 32'sd0;
            bus.out_valid <= 1'b0;
            bus.out_index <= 3'd0;
            bus.out_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= MAC;
                    busy  <= 1'b1;
                    n     <= 3'd0;
                    k     <= 3'd0;
                    acc   <= 32'sd0;
                end
                MAC: begin
                    if (k != 3'd0) acc <= acc + prod;
                    if (k == 3'd7) state <= FINISH;
                    else k <= k + 3'd1;
                end
                FINISH: begin
                    bus.out_data  <= sat;
                    bus.out_index <= n;
                    bus.out_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    k             <= 3'd0;
                    acc           <= 32'sd0;
                    if (n == 3'd7) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        n     <= n + 3'd1;
                        state <= MAC;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_idct_8_mac.sv
// tb_idct_8_mac: directed and random self-checking bench for idct_8_mac (honours IDCT_LEVEL_SHIFT_EN)
module tb_idct_8_mac;
    localparam int CW = 12;
    localparam int OW = 8;
`ifdef IDCT_LEVEL_SHIFT_EN
    localparam int SH = 128;
`else
    localparam int SH = 0;
`endif

    localparam int B [8][8] = '{
        '{91,  126,  118,  106,  91,   71,   49,   25},
        '{91,  106,   49,  -25, -91, -126, -118,  -71},
        '{91,   71,  -49, -126, -91,   25,  118,  106},
        '{91,   25, -118,  -71,  91,  106,  -49, -126},
        '{91,  -25, -118,   71,  91, -106,  -49,  126},
        '{91,  -71,  -49,  126, -91,  -25,  118, -106},
        '{91, -106,   49,   25, -91,  126, -118,   71},
        '{91, -126,  118, -106,  91,  -71,   49,  -25}
    };

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
    int   checks = 0;
    int   errors = 0;
    logic signed [CW-1:0] mem [8];

    idct_8_mac_if #(.COEF_WIDTH(CW), .OUT_WIDTH(OW)) bus ();

    idct_8_mac #(.COEF_WIDTH(CW), .OUT_WIDTH(OW)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) bus.fetch_data <= mem[bus.fetch_addr];

    function automatic int model(input int nn);
        int s;
        s = 0;
        for (int j = 0; j < 8; j++) s += int'(mem[j]) * B[nn][j];
        s = ((s + 128) >>> 8) + SH;
        if (s < SH - 128) s = SH - 128;
        if (s > SH + 127) s = SH + 127;
        return s;
    endfunction

    function automatic int obs_data();
`ifdef IDCT_LEVEL_SHIFT_EN
        return int'(bus.out_data);
`else
        return int'($signed(bus.out_data));
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mem();
        for (int j = 0; j < 8; j++) mem[j] = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " out_valid"}, int'(bus.out_valid), 0);
        chk({tag, " fetch_addr"}, int'(bus.fetch_addr), 0);
        chk({tag, " out_index"}, int'(bus.out_index), 0);
        chk({tag, " out_data"}, int'(bus.out_data), 0);
    endtask

    // mode 0: ready high; 1: random ready; 2: 5-cycle stall at n=3; 3: ready high plus start pulses while busy
    task automatic run_block(input string tag, input int mode, input bit use_fixed, input int fixed);
        int got, cyc, first, done_at, stall, e;
        got = 0; cyc = 0; first = -1; done_at = -1; stall = 0;
        bus.out_ready = (mode != 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (done_at < 0 && cyc < 4000) begin
            tick();
            cyc++;
            start = (mode == 3) && (cyc == 3 || cyc == 29);
            if (done) begin
                done_at = cyc;
                chk({tag, " busy at done"}, int'(busy), 0);
            end
            if (bus.out_valid) begin
                if (first < 0) first = cyc;
                e = use_fixed ? fixed : model(got);
                chk({tag, " out_index"}, int'(bus.out_index), got);
                chk({tag, " out_data"}, obs_data(), e);
                if (mode == 2 && got == 3 && stall < 5) begin
                    bus.out_ready = 1'b0;
                    stall++;
                    chk({tag, " stalled fetch_addr"}, int'(bus.fetch_addr), 7);
                    chk({tag, " stalled busy"}, int'(busy), 1);
                end else if (mode == 2) begin
                    bus.out_ready = 1'b1;
                end
                if (mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_ready) got++;
            end else if (mode == 1) begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        chk({tag, " sample count"}, got, 8);
        chk({tag, " done seen"}, int'(done_at >= 0), 1);
        if (mode == 0 || mode == 3) begin
            chk({tag, " first valid visible edge (handshake at E10)"}, first, 9);
            chk({tag, " done edge"}, done_at, 80);
        end
        if (mode == 2) chk({tag, " stall cycles"}, stall, 5);
        tick();
        chk({tag, " done one cycle"}, int'(done), 0);
        chk({tag, " idle busy"}, int'(busy), 0);
        chk({tag, " idle fetch_addr"}, int'(bus.fetch_addr), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b0;
        clear_mem();
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();
        chk_zero("idle");

        mem[0] = 12'sd64;
        run_block("dc64", 0, 1'b1, 23 + SH);

        clear_mem();
        run_block("zero", 3, 1'b1, 0 + SH);

        mem[0] = 12'sd2047;
        run_block("satpos", 0, 1'b1, 127 + SH);

        mem[0] = -12'sd2048;
        run_block("satneg", 0, 1'b1, -128 + SH);

        clear_mem();
        mem[1] = 12'sd100;
        run_block("ac100", 2, 1'b0, 0);

        for (int j = 0; j < 8; j++) mem[j] = CW'(j * 37 - 100);
        bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (43) tick();
        chk("pre-reset busy", int'(busy), 1);
        #3 reset = 1'b1;
        #1;
        chk_zero("midreset");
        repeat (2) begin
            tick();
            chk("midreset no done", int'(done), 0);
        end
        reset = 1'b0;
        repeat (2) begin
            tick();
            chk("after reset no done", int'(done), 0);
            chk("after reset idle", int'(busy), 0);
        end
        run_block("post-reset", 0, 1'b0, 0);

        for (int blk = 0; blk < 40; blk++) begin
            for (int j = 0; j < 8; j++) mem[j] = CW'($urandom_range(0, 4095));
            run_block("random", 1, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
